readback_sequencer: RTL and testbench
=====================================

// Module: readback_sequencer
// PURPOSE
//  Sequences post-capture readback: walks sample memory from newest to oldest, splits each
//  32-bit sample into bytes for enabled channel groups only, and feeds them to the SPI
//  transmitter over a valid/ready handshake. Sits between sample RAM and the SPI tx path;
//  started by the capture controller once the trigger/delay count is exhausted.
// PARAMETERS
//  ADDR_W   12  sample memory address width
//  CNT_W    16  width of read_count (number of samples to return)
// PORTS
//  clock            in   1        system clock; all logic on rising edge
//  reset_n          in   1        asynchronous active-low reset
//  start            in   1        one-cycle pulse: begin readback (ignored unless idle)
//  abort            in   1        one-cycle pulse: cancel (reset cmd 0x00); wins over all
//  read_count       in   CNT_W    samples to return; sampled on start
//  last_addr        in   ADDR_W   address of newest sample; sampled on start
//  disabled_groups  in   4        bit g=1 -> byte lane g (bits 8g+7:8g) not sent; sampled on start
//  mem_rd_req       out  1        one-cycle read request
//  mem_rd_addr      out  ADDR_W   read address, valid with mem_rd_req
//  mem_rd_valid     in   1        read data valid (any latency >=1 cycle after req)
//  mem_rd_data      in   32       sample word
//  tx_valid         out  1        byte available to SPI transmitter
//  tx_data          out  8        byte to send
//  tx_ready         in   1        transmitter accepts byte when tx_valid&tx_ready
//  busy             out  1        high from cycle after accepted start until idle
//  done             out  1        one-cycle pulse after last byte accepted
// BEHAVIOUR
//  Reset: state IDLE; mem_rd_req, tx_valid, busy, done = 0; tx_data, mem_rd_addr = 0.
//  FSM IDLE->FETCH->WAIT->SEND->(FETCH | DONE)->IDLE.
//   IDLE : on start latch inputs, addr<=last_addr, remaining<=read_count.
//          read_count==0 or disabled_groups==4'hF -> DONE (no reads, no bytes).
//   FETCH: mem_rd_req=1 for exactly one cycle, addr held -> WAIT.
//   WAIT : on mem_rd_valid capture word, lane<=lowest enabled group -> SEND.
//   SEND : tx_valid=1, tx_data=word lane; tx_data/tx_valid stable until tx_ready.
//          On accept: next enabled lane (ascending, group 0 first) else
//          remaining-1; if zero -> DONE, else addr-1 (mod 2^ADDR_W wrap) -> FETCH.
//   DONE : done=1 one cycle -> IDLE; busy drops the same cycle.
//  Throughput: one byte per cycle while tx_ready held high; 2-cycle + memory-latency bubble
//  between samples.
//  start while busy: ignored. start and abort same cycle: abort wins, stay IDLE.
//  abort in any state: IDLE next cycle, tx_valid/mem_rd_req drop, no done pulse;
//  late mem_rd_valid after abort is ignored.
//  mem_rd_valid outside WAIT is ignored. Address wrap 0 -> 2^ADDR_W-1 is legal.
//  Bytes sent per sample = number of zero bits in disabled_groups (1..4).
// CONFIGURATION
//  READBACK_CHECKSUM_EN defined: after last sample byte, one extra SEND of the XOR of all
//   transmitted bytes (8 bits, cleared on start), then DONE; not sent if zero bytes sent.
//  Undefined: no trailer byte; DONE directly after last sample byte.
// STRUCTURE
//  sump_pkg: rb_state_t enum (IDLE,FETCH,WAIT,SEND,DONE), NUM_GROUPS=4, GROUP_W=8,
//   function next_group(mask,cur) returning next enabled lane + valid flag.
//  Sub-module group_byte_select: combinational lane mux + next-lane priority encode from
//   disabled_groups and current lane; FSM and counters stay in readback_sequencer.
// TESTING
//  1 read_count=4, last_addr=3, disabled=4'hE, mem[3..0]=0x..44,..33,..22,..11, tx_ready=1
//    -> bytes 44,33,22,11 in order, 4 mem_rd_req at addr 3,2,1,0, one done pulse.
//  2 read_count=2, disabled=4'h5, mem[last]=0xAABBCCDD -> bytes CC,AA then next sample;
//    tx_ready toggled randomly -> tx_data never changes while tx_valid&!tx_ready.
//  3 last_addr=1, read_count=3 -> addresses 1,0,0xFFF; read_count=0 -> done 2 cycles
//    after start, no mem_rd_req, no tx_valid.
//  4 abort asserted mid-SEND and mid-WAIT (mem_rd_valid arrives later) -> idle next cycle,
//    no done, no further bytes; following start runs clean. start while busy -> ignored.
//  5 READBACK_CHECKSUM_EN, disabled=4'hC, samples 0x0102,0x0304 -> bytes 02,01,04,03,
//    then 0x04 (XOR), then done; disabled=4'hF -> no trailer, done only.
//  6 reset_n asserted asynchronously mid-SEND -> all outputs zero immediately, busy=0.

Source files
------------

// File: rtl/sump_pkg.sv
// Shared types and helpers for the post-capture readback path.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package sump_pkg;

  localparam int NUM_GROUPS = 4;
  localparam int GROUP_W    = 8;
  localparam int LANE_W     = 2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SEND,
    DONE
  } rb_state_t;

  typedef struct packed {
    logic              vld;
    logic [LANE_W-1:0] lane;
  } lane_sel_t;

  // Lowest enabled lane strictly above cur; vld=0 when none is left.
  function automatic lane_sel_t next_group(input logic [NUM_GROUPS-1:0] mask,
                                           input logic [LANE_W-1:0]     cur);
    lane_sel_t r;
    r = '0;
    for (int g = NUM_GROUPS - 1; g >= 0; g--) begin
      if ((g > int'(cur)) && !mask[g]) begin
        r.vld  = 1'b1;
        r.lane = LANE_W'(g);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/group_byte_select.sv
// Picks the current byte lane out of a sample word and encodes the first/next enabled lane.
// Latency: purely combinational.
// Backpressure: none; the sequencer decides when a lane advances.
import sump_pkg::*;

module group_byte_select (
  input  logic [NUM_GROUPS*GROUP_W-1:0] word,
  input  logic [NUM_GROUPS-1:0]         disabled_groups,
  input  logic [LANE_W-1:0]             lane,
  output logic [GROUP_W-1:0]            lane_byte,
  output logic [LANE_W-1:0]             first_lane,
  output logic [LANE_W-1:0]             next_lane,
  output logic                          next_vld
);

  lane_sel_t first_sel;
  lane_sel_t next_sel;

  // Byte of the current lane, lanes ordered from the least significant byte up.
  always_comb begin
    lane_byte = word[lane*GROUP_W +: GROUP_W];
  end

  // Lane 0 is the first lane unless masked; otherwise search upward from it.
  always_comb begin
    first_sel = next_group(disabled_groups, LANE_W'(0));
    if (!disabled_groups[0]) begin
      first_sel.vld  = 1'b1;
      first_sel.lane = '0;
    end
    first_lane = first_sel.lane;
  end

  assign next_sel  = next_group(disabled_groups, lane);
  assign next_lane = next_sel.lane;
  assign next_vld  = next_sel.vld;

endmodule

// File: rtl/readback_sequencer.sv
// Walks sample memory newest-to-oldest and streams enabled byte lanes to the SPI transmitter.
// Latency: one byte per cycle within a sample; FETCH + WAIT + memory latency between samples.
// Backpressure: tx_valid/tx_data held stable until tx_ready; READBACK_CHECKSUM_EN adds an XOR trailer byte.
import sump_pkg::*;

module readback_sequencer #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  read_count,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic [3:0]        disabled_groups,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_valid,
  input  logic [31:0]       mem_rd_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  rb_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [31:0]       word_q;
  logic [3:0]        mask_q;
  logic [1:0]        lane_q;
  logic [7:0]        lane_byte;
  logic [1:0]        first_lane;
  logic [1:0]        next_lane;
  logic              next_vld;
  logic              last_sample;
  logic              trailer_active;

  assign last_sample = (remaining_q == CNT_W'(1));
  assign mem_rd_addr = addr_q;

  group_byte_select u_sel (
    .word            (word_q),
    .disabled_groups (mask_q),
    .lane            (lane_q),
    .lane_byte       (lane_byte),
    .first_lane      (first_lane),
    .next_lane       (next_lane),
    .next_vld        (next_vld)
  );

`ifdef READBACK_CHECKSUM_EN
  logic [7:0] csum_q;
  logic       trailer_q;

  assign trailer_active = trailer_q;

  // Running XOR of every sample byte handed over; trailer_q marks the extra checksum beat.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      csum_q    <= '0;
      trailer_q <= 1'b0;
    end else if (abort) begin
      trailer_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      csum_q    <= '0;
      trailer_q <= 1'b0;
    end else if (state_q == SEND && tx_ready && !trailer_q) begin
      csum_q <= csum_q ^ lane_byte;
      if (!next_vld && last_sample) trailer_q <= 1'b1;
    end
  end
`else
  assign trailer_active = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and handshake outputs; abort overrides every transition.
  always_comb begin
    state_d    = state_q;
    mem_rd_req = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (read_count == '0 || disabled_groups == 4'hF) state_d = DONE;
          else                                               state_d = FETCH;
        end
      end
      FETCH: begin
        busy       = 1'b1;
        mem_rd_req = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (mem_rd_valid) state_d = SEND;
      end
      SEND: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = lane_byte;
`ifdef READBACK_CHECKSUM_EN
        if (trailer_q) tx_data = csum_q;
`endif
        if (tx_ready) begin
          if (trailer_active) begin
            state_d = DONE;
          end else if (!next_vld) begin
`ifdef READBACK_CHECKSUM_EN
            state_d = last_sample ? SEND : FETCH;
`else
            state_d = last_sample ? DONE : FETCH;
`endif
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Sample pointer, count and lane bookkeeping; frozen on abort since the run is discarded.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      remaining_q <= '0;
      word_q      <= '0;
      mask_q      <= '0;
      lane_q      <= '0;
    end else if (!abort) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q      <= last_addr;
            remaining_q <= read_count;
            mask_q      <= disabled_groups;
          end
        end
        WAIT: begin
          if (mem_rd_valid) begin
            word_q <= mem_rd_data;
            lane_q <= first_lane;
          end
        end
        SEND: begin
          if (tx_ready && !trailer_active) begin
            if (next_vld) begin
              lane_q <= next_lane;
            end else begin
              remaining_q <= remaining_q - CNT_W'(1);
              if (!last_sample) addr_q <= addr_q - ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_readback_sequencer.sv
// Directed bench for readback_sequencer with a queue-based model and a per-cycle compare process.
// Latency: n/a.
// Backpressure: tx_ready driven directly or randomly to exercise stalls.
module tb_readback_sequencer;

  localparam int ADDR_W = 12;
  localparam int CNT_W  = 16;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [CNT_W-1:0]  read_count = '0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [3:0]        disabled_groups = '0;
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_valid = 1'b0;
  logic [31:0]       mem_rd_data = '0;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready = 1'b0;
  logic              busy;
  logic              done;

  always #5 clock = ~clock;

  readback_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .abort           (abort),
    .read_count      (read_count),
    .last_addr       (last_addr),
    .disabled_groups (disabled_groups),
    .mem_rd_req      (mem_rd_req),
    .mem_rd_addr     (mem_rd_addr),
    .mem_rd_valid    (mem_rd_valid),
    .mem_rd_data     (mem_rd_data),
    .tx_valid        (tx_valid),
    .tx_data         (tx_data),
    .tx_ready        (tx_ready),
    .busy            (busy),
    .done            (done)
  );

  logic [31:0]       mem [0:4095];
  int                mem_lat = 1;
  logic [ADDR_W-1:0] mem_a;
  bit                rand_ready = 1'b0;

  logic [7:0]        exp_bytes[$];
  logic [7:0]        got_bytes[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [ADDR_W-1:0] got_addr[$];

  int checks = 0;
  int fails = 0;
  int done_seen = 0;
  int req_seen = 0;
  int txv_seen = 0;

  logic [7:0]        t1_b [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
  logic [ADDR_W-1:0] t1_a [4] = '{12'd3, 12'd2, 12'd1, 12'd0};
  logic [7:0]        t2_b [4] = '{8'hCC, 8'hAA, 8'h33, 8'h11};
  logic [ADDR_W-1:0] t3_a [3] = '{12'h001, 12'h000, 12'hFFF};
  logic [7:0]        t5_b [5] = '{8'h02, 8'h01, 8'h04, 8'h03, 8'h04};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Model: every sample newest-first, enabled lanes ascending, optional XOR trailer.
  task automatic expect_run(input int cnt, input logic [ADDR_W-1:0] last, input logic [3:0] dis);
    logic [ADDR_W-1:0] a;
    logic [31:0]       w;
`ifdef READBACK_CHECKSUM_EN
    logic [7:0]        x;
    x = '0;
`endif
    if (cnt == 0 || dis == 4'hF) return;
    for (int s = 0; s < cnt; s++) begin
      a = last - ADDR_W'(s);
      exp_addr.push_back(a);
      w = mem[a];
      for (int g = 0; g < 4; g++) begin
        if (!dis[g]) begin
          exp_bytes.push_back(w[8*g +: 8]);
`ifdef READBACK_CHECKSUM_EN
          x ^= w[8*g +: 8];
`endif
        end
      end
    end
`ifdef READBACK_CHECKSUM_EN
    exp_bytes.push_back(x);
`endif
  endtask

  task automatic pulse_start(input int cnt, input logic [ADDR_W-1:0] last,
                             input logic [3:0] dis, input bit do_model);
    read_count      = CNT_W'(cnt);
    last_addr       = last;
    disabled_groups = dis;
    start           = 1'b1;
    if (do_model) expect_run(cnt, last, dis);
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    int n;
    d0 = done_seen;
    n  = 0;
    while (done_seen == d0 && n < budget) begin
      tick(1);
      n++;
    end
    check(name, done_seen - d0, 1);
    tick(1);
  endtask

  task automatic wait_txv(input string name, input int budget);
    int n;
    n = 0;
    while (!tx_valid && n < budget) begin
      tick(1);
      n++;
    end
    check(name, tx_valid, 1'b1);
  endtask

  task automatic flush_model();
    exp_bytes.delete();
    exp_addr.delete();
  endtask

  task automatic clear_logs();
    got_bytes.delete();
    got_addr.delete();
  endtask

  // Memory responder: one outstanding read, data returned mem_lat cycles after the request.
  initial forever begin
    @(posedge clock);
    #1;
    if (mem_rd_req && reset_n) begin
      mem_a = mem_rd_addr;
      repeat (mem_lat) @(posedge clock);
      #1;
      mem_rd_valid = 1'b1;
      mem_rd_data  = mem[mem_a];
      @(posedge clock);
      #1;
      mem_rd_valid = 1'b0;
      mem_rd_data  = '0;
    end
  end

  // Random backpressure when enabled.
  initial forever begin
    @(posedge clock);
    #1;
    if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
  end

  // Compare process: sampled on the falling edge, mid-cycle.
  initial begin : compare
    bit         hold_prev;
    bit         abort_prev;
    bit         done_prev;
    logic [7:0] hold_data;
    hold_prev  = 1'b0;
    abort_prev = 1'b0;
    done_prev  = 1'b0;
    hold_data  = '0;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (mem_rd_req) begin
          req_seen++;
          got_addr.push_back(mem_rd_addr);
          check("req_expected", 32'(exp_addr.size() != 0), 1);
          if (exp_addr.size() != 0) check("rd_addr", mem_rd_addr, exp_addr.pop_front());
        end
        if (tx_valid) txv_seen++;
        if (hold_prev && !abort_prev) begin
          check("hold_valid", tx_valid, 1'b1);
          check("hold_data", tx_data, hold_data);
        end
        if (tx_valid && tx_ready) begin
          got_bytes.push_back(tx_data);
          check("byte_expected", 32'(exp_bytes.size() != 0), 1);
          if (exp_bytes.size() != 0) check("tx_data", tx_data, exp_bytes.pop_front());
        end
        if (done) begin
          done_seen++;
          check("done_bytes_left", exp_bytes.size(), 0);
          check("done_addrs_left", exp_addr.size(), 0);
          check("done_one_cycle", done_prev, 1'b0);
          check("busy_low_at_done", busy, 1'b0);
        end
        hold_prev  = tx_valid && !tx_ready;
        hold_data  = tx_data;
        abort_prev = abort;
        done_prev  = done;
      end else begin
        hold_prev = 1'b0;
        done_prev = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int d0;
    int r0;
    int t0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'(i) * 32'h9E37_79B1;

    // Reset values.
    tick(2);
    check("rst_req", mem_rd_req, 1'b0);
    check("rst_txv", tx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_txd", tx_data, 8'h00);
    check("rst_addr", mem_rd_addr, '0);
    reset_n = 1'b1;
    tick(1);
    tx_ready = 1'b1;

    // Single lane, four samples walking down to address 0.
    mem[3] = 32'hDEAD_BE44; mem[2] = 32'hDEAD_BE33;
    mem[1] = 32'hDEAD_BE22; mem[0] = 32'hDEAD_BE11;
    clear_logs();
    pulse_start(4, 12'd3, 4'hE, 1'b1);
    check("t1_busy", busy, 1'b1);
    wait_done("t1_done", 200);
    check("t1_nbytes", got_bytes.size(), 4);
    check("t1_naddr", got_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_bytes.size()) check("t1_byte_lit", got_bytes[i], t1_b[i]);
      if (i < got_addr.size()) check("t1_addr_lit", got_addr[i], t1_a[i]);
    end

    // Lanes 1 and 3 under random backpressure.
    mem[10] = 32'hAABB_CCDD; mem[9] = 32'h1122_3344;
    clear_logs();
    rand_ready = 1'b1;
    pulse_start(2, 12'd10, 4'h5, 1'b1);
    wait_done("t2_done", 400);
    rand_ready = 1'b0;
    tx_ready   = 1'b1;
    check("t2_nbytes", got_bytes.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < got_bytes.size()) check("t2_byte_lit", got_bytes[i], t2_b[i]);

    // Address wrap below zero.
    clear_logs();
    pulse_start(3, 12'd1, 4'h0, 1'b1);
    wait_done("t3_done", 200);
    check("t3_nbytes", got_bytes.size(), 12);
    for (int i = 0; i < 3; i++)
      if (i < got_addr.size()) check("t3_addr_lit", got_addr[i], t3_a[i]);

    // Zero count: immediate done, no reads, no bytes.
    d0 = done_seen; r0 = req_seen; t0 = txv_seen;
    pulse_start(0, 12'd7, 4'h0, 1'b1);
    tick(1);
    check("t3_zero_done", done_seen - d0, 1);
    check("t3_zero_req", req_seen - r0, 0);
    check("t3_zero_txv", txv_seen - t0, 0);
    check("t3_zero_busy", busy, 1'b0);

    // Abort while a byte is stalled in SEND.
    tx_ready = 1'b0;
    pulse_start(3, 12'd100, 4'h0, 1'b1);
    wait_txv("t4_reach_send", 20);
    tick(2);
    d0 = done_seen;
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    t0 = txv_seen;
    check("t4s_busy", busy, 1'b0);
    check("t4s_txv", tx_valid, 1'b0);
    check("t4s_req", mem_rd_req, 1'b0);
    tick(6);
    check("t4s_no_done", done_seen - d0, 0);
    check("t4s_no_bytes", txv_seen - t0, 0);
    flush_model();

    // Abort while waiting on a slow memory; the late data must be ignored.
    tx_ready = 1'b1;
    mem_lat  = 6;
    r0 = req_seen;
    pulse_start(2, 12'd200, 4'h0, 1'b1);
    for (int n = 0; n < 20 && req_seen == r0; n++) tick(1);
    check("t4w_req_seen", req_seen - r0, 1);
    d0 = done_seen; t0 = txv_seen;
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("t4w_busy", busy, 1'b0);
    tick(10);
    check("t4w_no_done", done_seen - d0, 0);
    check("t4w_no_bytes", txv_seen - t0, 0);
    check("t4w_idle", busy, 1'b0);
    flush_model();
    mem_lat = 1;

    // Clean run after aborts.
    clear_logs();
    pulse_start(2, 12'd200, 4'h0, 1'b1);
    wait_done("t4_clean_done", 200);
    check("t4_clean_nbytes", got_bytes.size(), 8);

    // Start while busy is ignored.
    clear_logs();
    tx_ready = 1'b0;
    r0 = req_seen;
    pulse_start(1, 12'd300, 4'hE, 1'b1);
    tick(3);
    pulse_start(5, 12'd50, 4'h0, 1'b0);
    tx_ready = 1'b1;
    wait_done("t4_busy_start_done", 200);
    check("t4_busy_start_reqs", req_seen - r0, 1);
    check("t4_busy_start_nbytes", got_bytes.size(), 1);

    // Two lanes, checksum trailer when enabled.
    mem[20] = 32'h0000_0102; mem[19] = 32'h0000_0304;
    clear_logs();
    pulse_start(2, 12'd20, 4'hC, 1'b1);
    wait_done("t5_done", 200);
`ifdef READBACK_CHECKSUM_EN
    check("t5_nbytes", got_bytes.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < got_bytes.size()) check("t5_byte_lit", got_bytes[i], t5_b[i]);
`else
    check("t5_nbytes", got_bytes.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < got_bytes.size()) check("t5_byte_lit", got_bytes[i], t5_b[i]);
`endif
    d0 = done_seen; r0 = req_seen; t0 = txv_seen;
    pulse_start(2, 12'd20, 4'hF, 1'b1);
    tick(1);
    check("t5_allmasked_done", done_seen - d0, 1);
    check("t5_allmasked_req", req_seen - r0, 0);
    check("t5_allmasked_txv", txv_seen - t0, 0);

    // Asynchronous reset in the middle of SEND.
    tx_ready = 1'b0;
    pulse_start(2, 12'd400, 4'h0, 1'b1);
    wait_txv("t6_reach_send", 20);
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_txv", tx_valid, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_req", mem_rd_req, 1'b0);
    check("t6_done", done, 1'b0);
    check("t6_txd", tx_data, 8'h00);
    flush_model();
    tick(2);
    reset_n  = 1'b1;
    tx_ready = 1'b1;
    tick(8);
    clear_logs();
    pulse_start(1, 12'd5, 4'h0, 1'b1);
    wait_done("t6_clean_done", 200);
    check("t6_clean_nbytes", got_bytes.size(), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
